// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: seeds, state encoding and LFSR feedback shared by the UART blocks
package uart_tx_pkg;
  localparam logic [10:0] SLOW_FULL_DEF = 11'h78c;
  localparam logic [10:0] FAST_FULL_DEF = 11'h68e;
  typedef enum logic [3:0] {IDLE, START, D0, D1, D2, D3, D4, D5, D6, D7, STOP} state_t;
  function automatic logic [10:0] lfsr_step(input logic [10:0] l);
    return {l[9:0], l[10] ^ l[8]};
  endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: LFSR bit-period timer; tc pulses once per period, rate latched on load
module uart_bit_timer
  import uart_tx_pkg::*;
#(
  parameter logic [10:0] SLOW_FULL = SLOW_FULL_DEF,
  parameter logic [10:0] FAST_FULL = FAST_FULL_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic high_speed,
  output logic tc
);
  logic [10:0] lfsr;
  logic        fast;
  assign tc = &lfsr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      lfsr <= SLOW_FULL;
      fast <= 1'b0;
    end else if (load) begin
      lfsr <= high_speed ? FAST_FULL : SLOW_FULL;
      fast <= high_speed;
    end else begin
      lfsr <= tc ? (fast ? FAST_FULL : SLOW_FULL) : lfsr_step(lfsr);
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8n1 transmitter with a one-byte holding buffer and seamless back-to-back frames
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter logic [10:0] SLOW_FULL = SLOW_FULL_DEF,
  parameter logic [10:0] FAST_FULL = FAST_FULL_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  input  logic       high_speed,
  output logic       busy
);
  state_t     state, state_d;
  logic [7:0] hold_byte, sh, sh_d;
  logic       hold_valid, tc, accept, start, line;
  assign ready  = ~hold_valid;
  assign accept = valid & ~hold_valid;
  assign start  = hold_valid & (state == IDLE | (state == STOP & tc));
  uart_bit_timer #(.SLOW_FULL(SLOW_FULL), .FAST_FULL(FAST_FULL)) u_timer (
    .clk(clk), .rst(rst), .load(start), .high_speed(high_speed), .tc(tc)
  );
  always_comb begin
    state_d = state;
    sh_d    = sh;
    if (start) begin
      state_d = START;
      sh_d    = hold_byte;
    end else if (state == STOP && tc) begin
      state_d = IDLE;
    end else if (state != IDLE && tc) begin
      state_d = state_t'(state + 4'd1);
      sh_d    = state == START ? sh : sh >> 1;
    end
  end
  // tx is registered from the current symbol, so the line trails the state by one cycle
  assign line = state == START ? 1'b0 : (state >= D0 && state <= D7) ? sh[0] : 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= IDLE;
      sh         <= '0;
      hold_byte  <= '0;
      hold_valid <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      sh         <= sh_d;
      hold_byte  <= accept ? data : hold_byte;
      hold_valid <= start ? 1'b0 : accept ? 1'b1 : hold_valid;
      tx         <= line;
      busy       <= state != IDLE || hold_valid;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench with a frame-level line model
module tb_uart_tx;
  localparam int PS = 1085, PF = 31;
  typedef struct {logic [7:0] b; bit fast;} exp_t;
  logic clk = 0, rst = 0, valid = 0, high_speed = 0;
  logic [7:0] data = 0;
  logic ready, tx, busy;
  int n_chk = 0, n_err = 0, cyc = 0, acc_cyc = 0, nframes = 0;
  exp_t exp_q[$];
  int starts[$];
  bit in_frame = 0;
  int pos = 0, per = PF, errs = 0;
  logic [9:0] bits = '1;
  exp_t cur;

  uart_tx dut (.clk(clk), .rst(rst), .data(data), .valid(valid), .ready(ready),
               .tx(tx), .high_speed(high_speed), .busy(busy));

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // line model: each frame is 10 symbols of P cycles, bits {stop, byte, start} sent LSB first
  always @(negedge clk) begin
    if (!rst) begin
      in_frame = 0;
      exp_q.delete();
    end else begin
      if (!in_frame && tx == 1'b0) begin
        if (exp_q.size() == 0) begin
          check("spurious_frame", 1, 0);
          cur.b = 8'h00;
          cur.fast = 1;
        end else cur = exp_q.pop_front();
        per = cur.fast ? PF : PS;
        bits = {1'b1, cur.b, 1'b0};
        in_frame = 1;
        pos = 0;
        errs = 0;
        starts.push_back(cyc);
        nframes++;
      end
      if (in_frame) begin
        if (tx !== bits[pos / per]) errs++;
        pos++;
        if (pos == 10 * per) begin
          in_frame = 0;
          check($sformatf("frame_%02h_%s", bits[8:1], per == PF ? "fast" : "slow"), errs, 0);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit fast);
    int n = 0;
    @(negedge clk);
    valid = 1;
    while (!ready && n < 30000) begin
      data = 8'($urandom);
      @(negedge clk);
      n++;
    end
    if (n >= 30000) check("accept_timeout", 0, 1);
    data = b;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    exp_q.push_back('{b, fast});
    valid = 0;
    data = 8'($urandom);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || in_frame || exp_q.size() != 0) && n < limit);
    if (n >= limit) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_edge(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int k, s0, n0, rdy;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    rst = 1;
    repeat (5) @(negedge clk);
    check("idle_tx", tx, 1);

    // single slow byte with latency and end-of-frame checks
    send(8'h55, 0);
    k = acc_cyc;
    check("lat_ready_low", ready, 0);
    @(posedge clk); #1;
    check("lat_tx_k1", tx, 1);
    check("lat_busy_k1", busy, 1);
    @(posedge clk); #1;
    check("lat_tx_k2", tx, 0);
    wait_edge(k + 2 + 5 * PS);
    check("mid_busy", busy, 1);
    wait_edge(k + 2 + 10 * PS);
    check("end_tx", tx, 1);
    check("end_busy", busy, 0);
    check("start_cycle", starts[$] - k, 2);
    wait_idle(1000);

    // back-to-back fast
    high_speed = 1;
    n0 = starts.size();
    send(8'hA5, 1);
    send(8'h3C, 1);
    rdy = 0;
    while (!ready && rdy < 1000) begin @(posedge clk); #1; rdy++; end
    rdy = cyc;
    wait_idle(2000);
    check("b2b_frames", starts.size() - n0, 2);
    check("b2b_gap", starts[n0 + 1] - starts[n0], 10 * PF);
    check("b2b_ready_back", rdy - starts[n0], 10 * PF - 1);

    // backpressure: third byte waits for the first frame to finish
    n0 = starts.size();
    send(8'h01, 1);
    send(8'h02, 1);
    send(8'h03, 1);
    k = acc_cyc;
    wait_idle(3000);
    check("bp_frames", starts.size() - n0, 3);
    check("bp_accept3", k - starts[n0], 10 * PF);
    check("bp_gap2", starts[n0 + 2] - starts[n0 + 1], 10 * PF);

    // rate latched at frame start
    high_speed = 0;
    n0 = starts.size();
    send(8'h0F, 0);
    repeat (3 * PS) @(negedge clk);
    high_speed = 1;
    send(8'h99, 1);
    wait_idle(20000);
    check("rate_gap", starts[n0 + 1] - starts[n0], 10 * PS);

    // reset during D3 with a byte held
    send(8'h5A, 1);
    send(8'hC3, 1);
    s0 = starts[$];
    wait_edge(s0 + 4 * PF + 10);
    #2 rst = 0;
    #1;
    check("mrst_tx", tx, 1);
    check("mrst_ready", ready, 1);
    check("mrst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1;
    n0 = nframes;
    repeat (25 * PF) @(negedge clk);
    check("mrst_no_frames", nframes - n0, 0);
    check("mrst_idle_tx", tx, 1);
    check("mrst_idle_busy", busy, 0);

    // random bytes with random gaps
    n0 = nframes;
    for (int i = 0; i < 30; i++) begin
      send(8'($urandom), 1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 400)) @(negedge clk);
    end
    wait_idle(20000);
    check("rand_frames", nframes - n0, 30);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8n1 UART transmitter; the transmit companion to the existing 8n1 receiver.
- Accepts bytes over a ready/valid handshake, buffers one byte, and serialises LSB-first: start bit, 8 data bits, stop bit.
- Bit period: 115200 baud at 125 MHz (1085 cycles), or 4M baud (31 cycles) when high_speed is set.
- Sits between the host-side byte source and the board tx pin.

Parameters:
- SLOW_FULL, 11'h78c: LFSR seed; all-ones is reached after 1085 cycles, giving one 115200-baud bit period.
- FAST_FULL, 11'h68e: LFSR seed; all-ones is reached after 31 cycles, giving one 4M-baud bit period.

Ports:
- clk  in  1  system clock, 125 MHz.
- rst  in  1  asynchronous, active-low reset. Asserting it (0) resets immediately; deassertion is synchronous to clk.
- data  in  8  byte to transmit.
- valid  in  1  data is valid.
- ready  out  1  holding buffer empty; a byte is accepted on a clk edge where valid && ready.
- tx  out  1  serial line, registered, idles high.
- high_speed  in  1  1 = 4M baud, 0 = 115200. Sampled only when a frame starts.
- busy  out  1  registered; high while a frame is on the line or a byte is held.

Behaviour:
- Reset values: tx=1, ready=1, busy=0, state=IDLE, holding buffer empty. Reset mid-frame aborts the frame and discards the buffered byte; tx returns high asynchronously.
- Holding buffer: one byte plus a hold_valid flag.
  - ready = !hold_valid, registered. There is no same-cycle pass-through.
  - On accept, hold_valid is set at that edge, so ready is low from the next cycle.
- Bit timer: 11-bit Fibonacci LFSR, next = {lfsr[9:0], lfsr[10]^lfsr[8]}, stepping every cycle. Terminal count is &lfsr. On terminal count it reloads with SLOW_FULL or FAST_FULL, using the rate latched at frame start.
- States: IDLE, START, D0..D7, STOP.
  - IDLE: tx=1. If hold_valid, go to START on the next edge:
    - shift register <= held byte; clear hold_valid;
    - latch high_speed; load the timer seed; tx <= 0.
  - START, D0..D6: on terminal count, advance one state and drive tx with the next data bit (LSB first).
  - D7: on terminal count, go to STOP with tx <= 1.
  - STOP: on terminal count:
    - if hold_valid, go directly to START (same actions as the IDLE exit), so there is no idle gap;
    - otherwise go to IDLE.
- Each line symbol lasts exactly P cycles (P=1085 slow, P=31 fast). A frame is 10*P cycles.
- Latency: a byte accepted at edge k into an empty IDLE transmitter moves to the shifter at edge k+1. tx falls at edge k+2.
- Back-to-back: a byte may be accepted at any time while the previous frame shifts. The next start bit begins on the cycle after the stop bit ends, giving continuous 10*P framing.
- high_speed changes mid-frame have no effect until the next START.
- busy = (state != IDLE) || hold_valid, registered.
- valid deasserted without acceptance: the byte is dropped with no side effect. data may change freely while ready=0.
- No parity, no break generation, no flow control pins.

Decomposition:
- Shared header (common.vh), shared with the receiver:
  - SLOW_FULL and FAST_FULL seed defaults;
  - state encodings IDLE..STOP;
  - the LFSR feedback taps.
- Sub-module uart_bit_timer:
  - function: LFSR, seed load, high_speed select, terminal-count output;
  - the receiver can later reuse it with half-period seeds.

Test Plan:
- Single byte, slow: rst released, send 0x55 with valid at edge k. Required:
  - ready=0 from k+1; tx falls at k+2;
  - line sequence 0,1,0,1,0,1,0,1,0,1, each symbol 1085 cycles;
  - tx=1 and busy=0 after 10850 cycles.
- Back-to-back, fast: send 0xA5 then 0x3C immediately. Required:
  - second start bit directly follows the first stop bit;
  - total 620 cycles with tx low at symbol boundaries per LSB-first bits;
  - ready reasserts one cycle after each holding-to-shifter transfer.
- Backpressure: present 0x01, 0x02, 0x03 continuously. Required:
  - 0x03 is not accepted (ready=0) until 0x01's frame completes;
  - all three bytes transmitted in order, no loss.
- Rate latch: start 0x0F slow, set high_speed=1 mid-frame. Required: 0x0F frame stays at 1085 cycles per symbol; the next byte transmits at 31 cycles per symbol.
- Reset mid-frame: assert rst=0 during D3 with a byte held. Required:
  - tx=1, ready=1, busy=0 immediately;
  - after release, no residual transmission.
- Loopback into uart_rx (fast): send 0x00, 0xFF, 0x80 back-to-back. Required: all three received, frame_error=0, overflow=0 when the receiver's consumer has ready=1.
